serial_mag_comparator: RTL

//   Multi-cycle N-bit unsigned magnitude comparator built around a 1-bit compare cell.
//   - Accepts two WIDTH-bit operands on a start pulse.
//   - Feeds them to the cell one bit per cycle, MSB first.
//   - Resolves greater / equal / less and holds the result under a valid/ready handshake.
//   - Sits directly downstream of the 1-bit cell: consumes its per-bit gt/eq/lt outputs.

---
 rtl/cmp_pkg.sv | 11 +
 rtl/bit_cmp_cell.sv | 12 +
 rtl/serial_mag_comparator.sv | 101 ++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared state and result encodings for the serial magnitude comparator
package cmp_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2
  } state_e;
  localparam logic [1:0] RES_GT = 2'b10;
  localparam logic [1:0] RES_EQ = 2'b00;
  localparam logic [1:0] RES_LT = 2'b01;
endpackage

// File: rtl/bit_cmp_cell.sv
// bit_cmp_cell: combinational 1-bit unsigned compare
module bit_cmp_cell (
  input  logic a_i,
  input  logic b_i,
  output logic gt_o,
  output logic eq_o,
  output logic lt_o
);
  assign gt_o = a_i & ~b_i;
  assign lt_o = ~a_i & b_i;
  assign eq_o = ~(a_i ^ b_i);
endmodule

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: MSB-first bit-serial unsigned compare with valid/ready result hold
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [WIDTH-1:0]           a_i,
  input  logic [WIDTH-1:0]           b_i,
  output logic                       busy_o,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic                       gt_o,
  output logic                       eq_o,
  output logic                       lt_o,
  output logic [$clog2(WIDTH+1)-1:0] cycles_o
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(WIDTH+1);
  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    cnt_q, cycles_q;
  logic [1:0]       res_q, res_d;
  logic             seen_q, valid_q, gt_q, eq_q, lt_q;
  logic             c_gt, c_eq, c_lt, done;
  bit_cmp_cell u_cell (
    .a_i  (a_q[WIDTH-1]),
    .b_i  (b_q[WIDTH-1]),
    .gt_o (c_gt),
    .eq_o (c_eq),
    .lt_o (c_lt)
  );
  // The first differing bit decides; {gt,lt} of the cell is already the result code.
  assign res_d = seen_q ? res_q : {c_gt, c_lt};
  assign done  = (EARLY_EXIT && !c_eq) || idx_q == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      cycles_q <= '0;
      res_q    <= RES_EQ;
      seen_q   <= 1'b0;
      valid_q  <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          a_q     <= a_i;
          b_q     <= b_i;
          idx_q   <= IW'(WIDTH-1);
          cnt_q   <= '0;
          seen_q  <= 1'b0;
          res_q   <= RES_EQ;
          state_q <= S_SCAN;
        end
        S_SCAN: begin
          a_q   <= a_q << 1;
          b_q   <= b_q << 1;
          idx_q <= idx_q - 1'b1;
          cnt_q <= cnt_q + 1'b1;
          if (!c_eq && !seen_q) begin
            seen_q <= 1'b1;
            res_q  <= {c_gt, c_lt};
          end
          if (done) begin
            gt_q     <= res_d == RES_GT;
            eq_q     <= res_d == RES_EQ;
            lt_q     <= res_d == RES_LT;
            cycles_q <= cnt_q + 1'b1;
            state_q  <= S_HOLD;
          end
        end
        S_HOLD: if (valid_q && res_ready_i) begin
          valid_q <= 1'b0;
          gt_q    <= 1'b0;
          eq_q    <= 1'b0;
          lt_q    <= 1'b0;
          state_q <= S_IDLE;
        end else begin
          valid_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign busy_o      = state_q != S_IDLE;
  assign res_valid_o = valid_q;
  assign gt_o        = gt_q;
  assign eq_o        = eq_q;
  assign lt_o        = lt_q;
  assign cycles_o    = cycles_q;
endmodule
